// File: rtl/mux_serializer.sv
// Serializes an accepted byte by walking the select of a downstream 8:1 mux,
// presenting one bit per out_ready handshake with a zero-gap reload on the final bit.
module mux_serializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       out_ready,
  output logic [2:0] sel,
  output logic [7:0] d_out,
  output logic       ser_out,
  output logic       out_valid,
  output logic       last
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [2:0] START_SEL = LSB_FIRST ? 3'd0 : 3'd7;
  localparam logic [2:0] FINAL_SEL = LSB_FIRST ? 3'd7 : 3'd0;

  state_t     state;
  logic [2:0] next_sel;
  logic       accept;

  assign next_sel = LSB_FIRST ? sel + 3'd1 : sel - 3'd1;

  // Reload is only possible on the edge that consumes the final bit; in_valid stays off this path.
  assign in_ready = (state == IDLE) || (last && out_ready);
  assign accept   = in_valid && in_ready;
  assign ser_out  = d_out[sel];

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values,
  // and the reset branch comes first so it overrides any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      d_out     <= 8'h00;
      sel       <= START_SEL;
      out_valid <= 1'b0;
      last      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            d_out     <= in_data;
            sel       <= START_SEL;
            state     <= SHIFT;
            out_valid <= 1'b1;
            last      <= 1'b0;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (last) begin
              sel  <= START_SEL;
              last <= 1'b0;
              if (accept) begin
                d_out <= in_data;
              end else begin
                state     <= IDLE;
                out_valid <= 1'b0;
              end
            end else begin
              sel  <= next_sel;
              last <= (next_sel == FINAL_SEL);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_serializer.sv
// Directed and scoreboard checks for mux_serializer in both bit orders.
module tb_mux_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       a_in_ready, a_ser_out, a_out_valid, a_last;
  logic [2:0] a_sel;
  logic [7:0] a_d_out;
  logic       b_in_ready, b_ser_out, b_out_valid, b_last;
  logic [2:0] b_sel;
  logic [7:0] b_d_out;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
    .out_ready(out_ready), .sel(a_sel), .d_out(a_d_out), .ser_out(a_ser_out),
    .out_valid(a_out_valid), .last(a_last)
  );

  mux_serializer #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .out_ready(out_ready), .sel(b_sel), .d_out(b_d_out), .ser_out(b_ser_out),
    .out_valid(b_out_valid), .last(b_last)
  );

  // Called at a negedge with both DUTs idle; returns at the negedge where bit 0 is shown.
  task automatic offer(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hAA; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
    checks++; if (a_d_out !== 8'h00) begin errors++; $display("FAIL reset_d_out got %h exp 00", a_d_out); end
    checks++; if (a_sel !== 3'd0) begin errors++; $display("FAIL reset_sel_lsb got %0d exp 0", a_sel); end
    checks++; if (b_sel !== 3'd7) begin errors++; $display("FAIL reset_sel_msb got %0d exp 7", b_sel); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", a_in_ready); end
    checks++; if (a_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", a_last); end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_hold got %b exp 0", a_out_valid); end
  endtask

  task automatic test_lsb_a5();
    logic seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    out_ready = 1'b1;
    offer(8'hA5);
    for (int i = 0; i < 8; i++) begin
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL lsb_valid[%0d] got %b exp 1", i, a_out_valid); end
      checks++; if (a_sel !== 3'(i)) begin errors++; $display("FAIL lsb_sel[%0d] got %0d exp %0d", i, a_sel, i); end
      checks++; if (a_ser_out !== seq[i]) begin errors++; $display("FAIL lsb_ser[%0d] got %b exp %b", i, a_ser_out, seq[i]); end
      checks++; if (a_last !== (i == 7)) begin errors++; $display("FAIL lsb_last[%0d] got %b exp %b", i, a_last, i == 7); end
      checks++; if (a_in_ready !== (i == 7)) begin errors++; $display("FAIL lsb_in_ready[%0d] got %b exp %b", i, a_in_ready, i == 7); end
      @(negedge clk);
    end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL lsb_idle got %b exp 0", a_out_valid); end
    checks++; if (a_sel !== 3'd0) begin errors++; $display("FAIL lsb_idle_sel got %0d exp 0", a_sel); end
  endtask

  task automatic test_msb_81();
    logic seq [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    offer(8'h81);
    for (int i = 0; i < 8; i++) begin
      checks++; if (b_sel !== 3'(7 - i)) begin errors++; $display("FAIL msb_sel[%0d] got %0d exp %0d", i, b_sel, 7 - i); end
      checks++; if (b_ser_out !== seq[i]) begin errors++; $display("FAIL msb_ser[%0d] got %b exp %b", i, b_ser_out, seq[i]); end
      checks++; if (b_last !== (i == 7)) begin errors++; $display("FAIL msb_last[%0d] got %b exp %b", i, b_last, i == 7); end
      @(negedge clk);
    end
    checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL msb_idle got %b exp 0", b_out_valid); end
    checks++; if (b_sel !== 3'd7) begin errors++; $display("FAIL msb_idle_sel got %0d exp 7", b_sel); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'hFF;
    @(negedge clk);
    in_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", i, a_out_valid); end
      checks++; if (a_ser_out !== (i < 8)) begin errors++; $display("FAIL b2b_ser[%0d] got %b exp %b", i, a_ser_out, i < 8); end
      checks++; if (a_sel !== 3'(i % 8)) begin errors++; $display("FAIL b2b_sel[%0d] got %0d exp %0d", i, a_sel, i % 8); end
      if (i < 15) begin
        checks++; if (a_in_ready !== (i == 7)) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b exp %b", i, a_in_ready, i == 7); end
      end
      if (i == 15) in_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", a_out_valid); end
    checks++; if (a_d_out !== 8'h00) begin errors++; $display("FAIL b2b_d_out got %h exp 00", a_d_out); end
  endtask

  task automatic test_stall();
    logic seq [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    int idx;
    out_ready = 1'b1;
    offer(8'h3C);
    for (int c = 0; c < 11; c++) begin
      idx = (c <= 3) ? c : (c <= 6) ? 3 : c - 3;
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", c, a_out_valid); end
      checks++; if (a_sel !== 3'(idx)) begin errors++; $display("FAIL stall_sel[%0d] got %0d exp %0d", c, a_sel, idx); end
      checks++; if (a_ser_out !== seq[idx]) begin errors++; $display("FAIL stall_ser[%0d] got %b exp %b", c, a_ser_out, seq[idx]); end
      checks++; if (a_last !== (idx == 7)) begin errors++; $display("FAIL stall_last[%0d] got %b exp %b", c, a_last, idx == 7); end
      out_ready = !(c >= 3 && c <= 5);
      @(negedge clk);
    end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stall_idle got %b exp 0", a_out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    offer(8'hC3);
    repeat (5) @(negedge clk);
    checks++; if (a_sel !== 3'd5) begin errors++; $display("FAIL rmid_pre_sel got %0d exp 5", a_sel); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", a_out_valid); end
    checks++; if (a_sel !== 3'd0) begin errors++; $display("FAIL rmid_sel got %0d exp 0", a_sel); end
    checks++; if (b_sel !== 3'd7) begin errors++; $display("FAIL rmid_sel_msb got %0d exp 7", b_sel); end
    checks++; if (a_d_out !== 8'h00) begin errors++; $display("FAIL rmid_d_out got %h exp 00", a_d_out); end
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b exp 1", a_in_ready); end
    offer(8'h5A);
    checks++; if (a_sel !== 3'd0) begin errors++; $display("FAIL rmid_new_sel got %0d exp 0", a_sel); end
    checks++; if (a_d_out !== 8'h5A) begin errors++; $display("FAIL rmid_new_d_out got %h exp 5A", a_d_out); end
    checks++; if (a_ser_out !== 1'b0) begin errors++; $display("FAIL rmid_new_ser got %b exp 0", a_ser_out); end
    repeat (8) @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rmid_drain got %b exp 0", a_out_valid); end
  endtask

  task automatic test_random();
    logic [7:0] exp_q [$];
    logic [7:0] frame = 8'h00;
    logic [7:0] want;
    int nbits = 0;
    int sent  = 0;
    int done  = 0;
    int cyc   = 0;
    while (done < 30 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      in_valid  = (sent < 30) && ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (in_valid && a_in_ready) begin
        exp_q.push_back(in_data);
        sent++;
      end
      if (a_out_valid && out_ready) begin
        frame[nbits] = a_ser_out;
        if (nbits == 7) begin
          checks++; if (a_last !== 1'b1) begin errors++; $display("FAIL rand_last_end[%0d] got %b exp 1", done, a_last); end
          want = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
          checks++; if (frame !== want) begin errors++; $display("FAIL rand_word[%0d] got %h exp %h", done, frame, want); end
          nbits = 0;
          done++;
        end else begin
          checks++; if (a_last !== 1'b0) begin errors++; $display("FAIL rand_last_mid[%0d.%0d] got %b exp 0", done, nbits, a_last); end
          nbits++;
        end
      end
    end
    checks++; if (done != 30) begin errors++; $display("FAIL rand_timeout got %0d frames exp 30", done); end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rand_idle got %b exp 0", a_out_valid); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    test_reset();
    test_lsb_a5();
    test_msb_81();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
